// File: rtl/pipe_commit_tracer.sv
// pipe_commit_tracer: write-back commit trace buffer with free-run/PC-trigger capture and valid/ready readout
// Ports:
//   clk, rst (async, active-low)
//   cap_valid/cap_pc/cap_instr/cap_rd/cap_wdata/cap_fwd : commit record input
//   cfg_mode/cfg_trig_pc/cfg_post                     : capture configuration
//   arm/stop                                          : capture control pulses
//   rd_valid/rd_ready/rd_data/rd_last                 : oldest-first readout port
//   state/count/triggered/overflow                    : status
module pipe_commit_tracer #(
  parameter int DEPTH = 64,
  parameter int XLEN = 32,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int ENTRY_W = 2 * XLEN + 41
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_valid,
  input  logic [XLEN-1:0]    cap_pc,
  input  logic [31:0]        cap_instr,
  input  logic [4:0]         cap_rd,
  input  logic [XLEN-1:0]    cap_wdata,
  input  logic [3:0]         cap_fwd,
  input  logic               cfg_mode,
  input  logic [XLEN-1:0]    cfg_trig_pc,
  input  logic [CW-1:0]      cfg_post,
  input  logic               arm,
  input  logic               stop,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [CW-1:0]      count,
  output logic               triggered,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t st;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_addr;
  logic [CW-1:0] post_cnt, post_load, next_count;
  logic capturing, we, trig, pop;
  assign state = st;
  always_comb begin
    capturing = (st == ARMED || st == POST) && !arm;
    we = capturing && cap_valid;
    trig = we && st == ARMED && cfg_mode && cap_pc == cfg_trig_pc;
    post_load = cfg_post > MAX_POST ? MAX_POST : cfg_post;
    pop = st == DONE && rd_valid && rd_ready;
    next_count = count - CW'(pop);
    // oldest surviving record after this cycle's pop; a full count wraps back to wr_ptr
    rd_addr = wr_ptr - next_count[AW-1:0];
  end
  always_ff @(posedge clk) if (we) mem[wr_ptr] <= {cap_pc, cap_instr, cap_rd, cap_wdata, cap_fwd};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      wr_ptr <= '0;
      count <= '0;
      post_cnt <= '0;
      triggered <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      rd_data <= '0;
    end else if (arm) begin
      st <= ARMED;
      wr_ptr <= '0;
      count <= '0;
      post_cnt <= '0;
      triggered <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count == FULL) overflow <= 1'b1;
        else count <= count + CW'(1);
      end
      if (trig) begin
        triggered <= 1'b1;
        post_cnt <= post_load;
      end
      if (we && st == POST) post_cnt <= post_cnt - CW'(1);
      if (capturing && stop) st <= DONE;
      else if (trig) st <= post_load == '0 ? DONE : POST;
      else if (we && st == POST && post_cnt == CW'(1)) st <= DONE;
      // readout is re-registered every DONE cycle; with no pop the address and contents are unchanged, so outputs hold
      if (st == DONE) begin
        count <= next_count;
        rd_valid <= next_count != '0;
        rd_last <= next_count == CW'(1);
        rd_data <= mem[rd_addr];
      end
    end
  end
endmodule
